// File: rtl/axi_read_router_pkg.sv
// Shared types and address-decode constants for the AXI read router.
// Slave select values double as the slave index used by the R/AR muxes.
package axi_read_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_S0 = 2'd0,
        SEL_S1 = 2'd1,
        SEL_S2 = 2'd2,
        SEL_SD = 2'd3
    } sel_e;

    localparam logic [15:0] DEC_S0 = 16'h0000;
    localparam logic [15:0] DEC_S1 = 16'h0001;
    localparam logic [15:0] DEC_S2 = 16'h0002;

endpackage

// File: rtl/axi_read_router_rr_arbiter2.sv
// Two-request round-robin arbiter: a single priority bit that flips whenever
// a granted burst completes. The grant is combinational; the caller registers it.
module rr_arbiter2 (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       gnt_o
);

    logic prio_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            prio_q <= 1'b0;
        end else if (update_i) begin
            prio_q <= ~prio_q;
        end
    end

    // A lone requester wins outright; a tie goes to the priority holder.
    assign gnt_o = (req_i[0] & req_i[1]) ? prio_q : req_i[1];

endmodule

// File: rtl/axi_read_router.sv
// Two-master, four-slave AXI read router with one transaction in flight.
// Grant and slave select are frozen from IDLE exit until the RLAST handshake.
//
// state | meaning
// IDLE  | no transaction; all outputs inactive, arbitrate and decode
// ADDR  | AR beat forwarded to selected slave, waiting for handshake
// DATA  | R beats routed back to granted master until RLAST handshake
module axi_read_router
    import axi_read_router_pkg::*;
#(
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,

    input  logic [ID_BITS-1:0]   ARID_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    input  logic [3:0]           ARLEN_M0,
    input  logic [2:0]           ARSIZE_M0,
    input  logic [1:0]           ARBURST_M0,
    input  logic                 ARVALID_M0,
    output logic                 ARREADY_M0,
    output logic [ID_BITS-1:0]   RID_M0,
    output logic [DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]           RRESP_M0,
    output logic                 RLAST_M0,
    output logic                 RVALID_M0,
    input  logic                 RREADY_M0,

    input  logic [ID_BITS-1:0]   ARID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    input  logic [3:0]           ARLEN_M1,
    input  logic [2:0]           ARSIZE_M1,
    input  logic [1:0]           ARBURST_M1,
    input  logic                 ARVALID_M1,
    output logic                 ARREADY_M1,
    output logic [ID_BITS-1:0]   RID_M1,
    output logic [DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]           RRESP_M1,
    output logic                 RLAST_M1,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M1,

    output logic [IDS_BITS-1:0]  ARID_S0,
    output logic [ADDR_BITS-1:0] ARADDR_S0,
    output logic [3:0]           ARLEN_S0,
    output logic [2:0]           ARSIZE_S0,
    output logic [1:0]           ARBURST_S0,
    output logic                 ARVALID_S0,
    input  logic                 ARREADY_S0,
    input  logic [IDS_BITS-1:0]  RID_S0,
    input  logic [DATA_BITS-1:0] RDATA_S0,
    input  logic [1:0]           RRESP_S0,
    input  logic                 RLAST_S0,
    input  logic                 RVALID_S0,
    output logic                 RREADY_S0,

    output logic [IDS_BITS-1:0]  ARID_S1,
    output logic [ADDR_BITS-1:0] ARADDR_S1,
    output logic [3:0]           ARLEN_S1,
    output logic [2:0]           ARSIZE_S1,
    output logic [1:0]           ARBURST_S1,
    output logic                 ARVALID_S1,
    input  logic                 ARREADY_S1,
    input  logic [IDS_BITS-1:0]  RID_S1,
    input  logic [DATA_BITS-1:0] RDATA_S1,
    input  logic [1:0]           RRESP_S1,
    input  logic                 RLAST_S1,
    input  logic                 RVALID_S1,
    output logic                 RREADY_S1,

    output logic [IDS_BITS-1:0]  ARID_S2,
    output logic [ADDR_BITS-1:0] ARADDR_S2,
    output logic [3:0]           ARLEN_S2,
    output logic [2:0]           ARSIZE_S2,
    output logic [1:0]           ARBURST_S2,
    output logic                 ARVALID_S2,
    input  logic                 ARREADY_S2,
    input  logic [IDS_BITS-1:0]  RID_S2,
    input  logic [DATA_BITS-1:0] RDATA_S2,
    input  logic [1:0]           RRESP_S2,
    input  logic                 RLAST_S2,
    input  logic                 RVALID_S2,
    output logic                 RREADY_S2,

    output logic [IDS_BITS-1:0]  ARID_SD,
    output logic [3:0]           ARLEN_SD,
    output logic                 ARVALID_SD,
    input  logic                 ARREADY_SD,
    input  logic [IDS_BITS-1:0]  RID_SD,
    input  logic [DATA_BITS-1:0] RDATA_SD,
    input  logic [1:0]           RRESP_SD,
    input  logic                 RLAST_SD,
    input  logic                 RVALID_SD,
    output logic                 RREADY_SD
);

    localparam int PAD_BITS = IDS_BITS - ID_BITS - 1;

    function automatic sel_e decode(input logic [15:0] page);
        case (page)
            DEC_S0:  decode = SEL_S0;
            DEC_S1:  decode = SEL_S1;
            DEC_S2:  decode = SEL_S2;
            default: decode = SEL_SD;
        endcase
    endfunction

    state_e state_q;
    logic   grant_q;
    sel_e   sel_q;

    logic                 arb_gnt;
    logic                 r_done;
    logic                 ar_hs;
    logic                 in_addr, in_data;
    logic [15:0]          arb_page;

    logic [ID_BITS-1:0]   g_arid;
    logic [IDS_BITS-1:0]  g_arid_s;
    logic [ADDR_BITS-1:0] g_araddr;
    logic [3:0]           g_arlen;
    logic [2:0]           g_arsize;
    logic [1:0]           g_arburst;
    logic                 g_arvalid;
    logic                 g_rready;

    logic                 sl_arready;
    logic                 sl_rvalid;
    logic [ID_BITS-1:0]   sl_rid;
    logic [DATA_BITS-1:0] sl_rdata;
    logic [1:0]           sl_rresp;
    logic                 sl_rlast;

    logic ar_s0, ar_s1, ar_s2, ar_sd;
    logic r_s0, r_s1, r_s2, r_sd;
    logic r_m0, r_m1;

    // Upper slave-side ID bits carry our own grant index; they are not returned.
    logic unused_rid_hi;
    assign unused_rid_hi = ^{RID_S0[IDS_BITS-1:ID_BITS], RID_S1[IDS_BITS-1:ID_BITS],
                             RID_S2[IDS_BITS-1:ID_BITS], RID_SD[IDS_BITS-1:ID_BITS]};

    rr_arbiter2 u_arb (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .req_i    ({ARVALID_M1, ARVALID_M0}),
        .update_i (r_done),
        .gnt_o    (arb_gnt)
    );

    assign arb_page = arb_gnt ? ARADDR_M1[ADDR_BITS-1 -: 16] : ARADDR_M0[ADDR_BITS-1 -: 16];

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            sel_q   <= SEL_S0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ARVALID_M0 || ARVALID_M1) begin
                        grant_q <= arb_gnt;
                        sel_q   <= decode(arb_page);
                        state_q <= ADDR;
                    end
                end
                ADDR: if (ar_hs) state_q <= DATA;
                DATA: if (r_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign g_arid    = grant_q ? ARID_M1    : ARID_M0;
    assign g_araddr  = grant_q ? ARADDR_M1  : ARADDR_M0;
    assign g_arlen   = grant_q ? ARLEN_M1   : ARLEN_M0;
    assign g_arsize  = grant_q ? ARSIZE_M1  : ARSIZE_M0;
    assign g_arburst = grant_q ? ARBURST_M1 : ARBURST_M0;
    assign g_arvalid = grant_q ? ARVALID_M1 : ARVALID_M0;
    assign g_rready  = grant_q ? RREADY_M1  : RREADY_M0;
    assign g_arid_s  = {{PAD_BITS{1'b0}}, grant_q, g_arid};

    always_comb begin
        sl_arready = 1'b0;
        sl_rvalid  = 1'b0;
        sl_rid     = '0;
        sl_rdata   = '0;
        sl_rresp   = '0;
        sl_rlast   = 1'b0;
        case (sel_q)
            SEL_S0: begin
                sl_arready = ARREADY_S0; sl_rvalid = RVALID_S0; sl_rid = RID_S0[ID_BITS-1:0];
                sl_rdata = RDATA_S0; sl_rresp = RRESP_S0; sl_rlast = RLAST_S0;
            end
            SEL_S1: begin
                sl_arready = ARREADY_S1; sl_rvalid = RVALID_S1; sl_rid = RID_S1[ID_BITS-1:0];
                sl_rdata = RDATA_S1; sl_rresp = RRESP_S1; sl_rlast = RLAST_S1;
            end
            SEL_S2: begin
                sl_arready = ARREADY_S2; sl_rvalid = RVALID_S2; sl_rid = RID_S2[ID_BITS-1:0];
                sl_rdata = RDATA_S2; sl_rresp = RRESP_S2; sl_rlast = RLAST_S2;
            end
            default: begin
                sl_arready = ARREADY_SD; sl_rvalid = RVALID_SD; sl_rid = RID_SD[ID_BITS-1:0];
                sl_rdata = RDATA_SD; sl_rresp = RRESP_SD; sl_rlast = RLAST_SD;
            end
        endcase
    end

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);
    assign ar_hs   = in_addr & g_arvalid & sl_arready;
    assign r_done  = in_data & sl_rvalid & g_rready & sl_rlast;

    assign ar_s0 = in_addr & (sel_q == SEL_S0);
    assign ar_s1 = in_addr & (sel_q == SEL_S1);
    assign ar_s2 = in_addr & (sel_q == SEL_S2);
    assign ar_sd = in_addr & (sel_q == SEL_SD);
    assign r_s0  = in_data & (sel_q == SEL_S0);
    assign r_s1  = in_data & (sel_q == SEL_S1);
    assign r_s2  = in_data & (sel_q == SEL_S2);
    assign r_sd  = in_data & (sel_q == SEL_SD);
    assign r_m0  = in_data & ~grant_q;
    assign r_m1  = in_data &  grant_q;

    assign ARVALID_S0 = ar_s0 & g_arvalid;
    assign ARID_S0    = ar_s0 ? g_arid_s  : '0;
    assign ARADDR_S0  = ar_s0 ? g_araddr  : '0;
    assign ARLEN_S0   = ar_s0 ? g_arlen   : '0;
    assign ARSIZE_S0  = ar_s0 ? g_arsize  : '0;
    assign ARBURST_S0 = ar_s0 ? g_arburst : '0;

    assign ARVALID_S1 = ar_s1 & g_arvalid;
    assign ARID_S1    = ar_s1 ? g_arid_s  : '0;
    assign ARADDR_S1  = ar_s1 ? g_araddr  : '0;
    assign ARLEN_S1   = ar_s1 ? g_arlen   : '0;
    assign ARSIZE_S1  = ar_s1 ? g_arsize  : '0;
    assign ARBURST_S1 = ar_s1 ? g_arburst : '0;

    assign ARVALID_S2 = ar_s2 & g_arvalid;
    assign ARID_S2    = ar_s2 ? g_arid_s  : '0;
    assign ARADDR_S2  = ar_s2 ? g_araddr  : '0;
    assign ARLEN_S2   = ar_s2 ? g_arlen   : '0;
    assign ARSIZE_S2  = ar_s2 ? g_arsize  : '0;
    assign ARBURST_S2 = ar_s2 ? g_arburst : '0;

    assign ARVALID_SD = ar_sd & g_arvalid;
    assign ARID_SD    = ar_sd ? g_arid_s : '0;
    assign ARLEN_SD   = ar_sd ? g_arlen  : '0;

    assign ARREADY_M0 = in_addr & ~grant_q & sl_arready;
    assign ARREADY_M1 = in_addr &  grant_q & sl_arready;

    assign RVALID_M0 = r_m0 & sl_rvalid;
    assign RID_M0    = r_m0 ? sl_rid   : '0;
    assign RDATA_M0  = r_m0 ? sl_rdata : '0;
    assign RRESP_M0  = r_m0 ? sl_rresp : '0;
    assign RLAST_M0  = r_m0 & sl_rlast;

    assign RVALID_M1 = r_m1 & sl_rvalid;
    assign RID_M1    = r_m1 ? sl_rid   : '0;
    assign RDATA_M1  = r_m1 ? sl_rdata : '0;
    assign RRESP_M1  = r_m1 ? sl_rresp : '0;
    assign RLAST_M1  = r_m1 & sl_rlast;

    assign RREADY_S0 = r_s0 & g_rready;
    assign RREADY_S1 = r_s1 & g_rready;
    assign RREADY_S2 = r_s2 & g_rready;
    assign RREADY_SD = r_sd & g_rready;

endmodule

// File: tb/tb_axi_read_router.sv
// Directed bench for axi_read_router: each task drives one scenario and checks
// the router outputs against hand-derived values.
module tb_axi_read_router;

    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;

    logic [7:0]  ARID_S0, ARID_S1, ARID_S2, ARID_SD;
    logic [31:0] ARADDR_S0, ARADDR_S1, ARADDR_S2;
    logic [3:0]  ARLEN_S0, ARLEN_S1, ARLEN_S2, ARLEN_SD;
    logic [2:0]  ARSIZE_S0, ARSIZE_S1, ARSIZE_S2;
    logic [1:0]  ARBURST_S0, ARBURST_S1, ARBURST_S2;
    logic        ARVALID_S0, ARVALID_S1, ARVALID_S2, ARVALID_SD;
    logic        ARREADY_S0, ARREADY_S1, ARREADY_S2, ARREADY_SD;
    logic [7:0]  RID_S0, RID_S1, RID_S2, RID_SD;
    logic [31:0] RDATA_S0, RDATA_S1, RDATA_S2, RDATA_SD;
    logic [1:0]  RRESP_S0, RRESP_S1, RRESP_S2, RRESP_SD;
    logic        RLAST_S0, RLAST_S1, RLAST_S2, RLAST_SD;
    logic        RVALID_S0, RVALID_S1, RVALID_S2, RVALID_SD;
    logic        RREADY_S0, RREADY_S1, RREADY_S2, RREADY_SD;

    int n_cmp = 0;
    int n_err = 0;

    axi_read_router dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .ARID_S0(ARID_S0), .ARADDR_S0(ARADDR_S0), .ARLEN_S0(ARLEN_S0), .ARSIZE_S0(ARSIZE_S0),
        .ARBURST_S0(ARBURST_S0), .ARVALID_S0(ARVALID_S0), .ARREADY_S0(ARREADY_S0),
        .RID_S0(RID_S0), .RDATA_S0(RDATA_S0), .RRESP_S0(RRESP_S0), .RLAST_S0(RLAST_S0),
        .RVALID_S0(RVALID_S0), .RREADY_S0(RREADY_S0),
        .ARID_S1(ARID_S1), .ARADDR_S1(ARADDR_S1), .ARLEN_S1(ARLEN_S1), .ARSIZE_S1(ARSIZE_S1),
        .ARBURST_S1(ARBURST_S1), .ARVALID_S1(ARVALID_S1), .ARREADY_S1(ARREADY_S1),
        .RID_S1(RID_S1), .RDATA_S1(RDATA_S1), .RRESP_S1(RRESP_S1), .RLAST_S1(RLAST_S1),
        .RVALID_S1(RVALID_S1), .RREADY_S1(RREADY_S1),
        .ARID_S2(ARID_S2), .ARADDR_S2(ARADDR_S2), .ARLEN_S2(ARLEN_S2), .ARSIZE_S2(ARSIZE_S2),
        .ARBURST_S2(ARBURST_S2), .ARVALID_S2(ARVALID_S2), .ARREADY_S2(ARREADY_S2),
        .RID_S2(RID_S2), .RDATA_S2(RDATA_S2), .RRESP_S2(RRESP_S2), .RLAST_S2(RLAST_S2),
        .RVALID_S2(RVALID_S2), .RREADY_S2(RREADY_S2),
        .ARID_SD(ARID_SD), .ARLEN_SD(ARLEN_SD), .ARVALID_SD(ARVALID_SD), .ARREADY_SD(ARREADY_SD),
        .RID_SD(RID_SD), .RDATA_SD(RDATA_SD), .RRESP_SD(RRESP_SD), .RLAST_SD(RLAST_SD),
        .RVALID_SD(RVALID_SD), .RREADY_SD(RREADY_SD)
    );

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_ar();
        ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = '0; ARBURST_M0 = '0; ARVALID_M0 = 1'b0;
        ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = '0; ARBURST_M1 = '0; ARVALID_M1 = 1'b0;
        ARREADY_S0 = 1'b0; ARREADY_S1 = 1'b0; ARREADY_S2 = 1'b0; ARREADY_SD = 1'b0;
    endtask

    task automatic clear_r();
        RID_S0 = '0; RDATA_S0 = '0; RRESP_S0 = '0; RLAST_S0 = 1'b0; RVALID_S0 = 1'b0;
        RID_S1 = '0; RDATA_S1 = '0; RRESP_S1 = '0; RLAST_S1 = 1'b0; RVALID_S1 = 1'b0;
        RID_S2 = '0; RDATA_S2 = '0; RRESP_S2 = '0; RLAST_S2 = 1'b0; RVALID_S2 = 1'b0;
        RID_SD = '0; RDATA_SD = '0; RRESP_SD = '0; RLAST_SD = 1'b0; RVALID_SD = 1'b0;
        RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] ctl;
        ARESETn = 1'b0;
        clear_ar();
        clear_r();
        ARVALID_M0 = 1'b1;
        ARADDR_M0  = 32'h0000_0004;
        ARREADY_S0 = 1'b1;
        cyc(); cyc(); cyc();
        ctl = {ARVALID_S0, ARVALID_S1, ARVALID_S2, ARVALID_SD, ARREADY_M0, ARREADY_M1,
               RVALID_M0, RVALID_M1, RREADY_S0, RREADY_S1, RREADY_S2, RREADY_SD};
        n_cmp++;
        if (ctl !== 12'h000) begin
            n_err++; $display("FAIL reset_ctl: got %h want 000", ctl);
        end
        n_cmp++;
        if ({ARID_S0, ARADDR_S0, RDATA_M0, RID_M0} !== 76'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {ARID_S0, ARADDR_S0, RDATA_M0, RID_M0});
        end
        ARESETn = 1'b1;
        clear_ar();
        cyc();
    endtask

    task automatic test_single_s0();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0000_0010; ARLEN_M0 = 4'd0; ARID_M0 = 4'h3;
        ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1; ARREADY_S0 = 1'b1;
        #1;
        n_cmp++;
        if (ARVALID_S0 !== 1'b0) begin n_err++; $display("FAIL s0_idle_arvalid: got %b want 0", ARVALID_S0); end
        cyc();
        n_cmp++;
        if (ARVALID_S0 !== 1'b1) begin n_err++; $display("FAIL s0_arvalid: got %b want 1", ARVALID_S0); end
        n_cmp++;
        if (ARID_S0 !== 8'h03) begin n_err++; $display("FAIL s0_arid: got %h want 03", ARID_S0); end
        n_cmp++;
        if ({ARADDR_S0, ARSIZE_S0, ARBURST_S0} !== {32'h0000_0010, 3'd2, 2'd1}) begin
            n_err++; $display("FAIL s0_arfields: got %h/%h/%h want 00000010/2/1", ARADDR_S0, ARSIZE_S0, ARBURST_S0);
        end
        n_cmp++;
        if ({ARREADY_M0, ARREADY_M1, ARVALID_S1} !== 3'b100) begin
            n_err++; $display("FAIL s0_arready: got %b want 100", {ARREADY_M0, ARREADY_M1, ARVALID_S1});
        end
        cyc();
        clear_ar();
        RVALID_S0 = 1'b1; RID_S0 = 8'h03; RDATA_S0 = 32'hCAFE_0001; RLAST_S0 = 1'b1; RREADY_M0 = 1'b1;
        #1;
        n_cmp++;
        if ({RVALID_M0, RID_M0, RLAST_M0, RREADY_S0} !== {1'b1, 4'h3, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL s0_rbeat: got v%b id%h l%b rr%b want v1 id3 l1 rr1",
                              RVALID_M0, RID_M0, RLAST_M0, RREADY_S0);
        end
        n_cmp++;
        if (RDATA_M0 !== 32'hCAFE_0001) begin n_err++; $display("FAIL s0_rdata: got %h want cafe0001", RDATA_M0); end
        cyc();
        n_cmp++;
        if ({RVALID_M0, RREADY_S0} !== 2'b00) begin
            n_err++; $display("FAIL s0_after_last: got %b want 00", {RVALID_M0, RREADY_S0});
        end
        clear_r();
    endtask

    task automatic test_burst_s2();
        int got;
        got = 0;
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0002_0100; ARLEN_M1 = 4'd3; ARID_M1 = 4'h5; ARREADY_S2 = 1'b1;
        cyc();
        n_cmp++;
        if ({ARVALID_S2, ARID_S2, ARLEN_S2} !== {1'b1, 8'h15, 4'd3}) begin
            n_err++; $display("FAIL s2_ar: got v%b id%h len%h want v1 id15 len3", ARVALID_S2, ARID_S2, ARLEN_S2);
        end
        n_cmp++;
        if ({ARREADY_M1, ARREADY_M0, ARVALID_S0} !== 3'b100) begin
            n_err++; $display("FAIL s2_arready: got %b want 100", {ARREADY_M1, ARREADY_M0, ARVALID_S0});
        end
        cyc();
        clear_ar();
        RREADY_M1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            RVALID_S2 = 1'b1; RID_S2 = 8'h15; RDATA_S2 = 32'hB000_0000 + i; RLAST_S2 = (i == 3);
            if (i == 2) begin
                RREADY_M1 = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    #1;
                    n_cmp++;
                    if ({RREADY_S2, RVALID_M1} !== 2'b01) begin
                        n_err++; $display("FAIL s2_stall: got rr%b v%b want rr0 v1", RREADY_S2, RVALID_M1);
                    end
                    cyc();
                end
                RREADY_M1 = 1'b1;
            end
            #1;
            n_cmp++;
            if ({RREADY_S2, RID_M1, RDATA_M1, RLAST_M1} !== {1'b1, 4'h5, 32'hB000_0000 + i, (i == 3)}) begin
                n_err++; $display("FAIL s2_beat%0d: got rr%b id%h d%h l%b want rr1 id5 d%h l%b",
                                  i, RREADY_S2, RID_M1, RDATA_M1, RLAST_M1, 32'hB000_0000 + i, (i == 3));
            end
            if (RVALID_M1 && RREADY_M1) got++;
            cyc();
        end
        clear_r();
        #1;
        n_cmp++;
        if (got !== 4) begin n_err++; $display("FAIL s2_beats: got %0d want 4", got); end
        n_cmp++;
        if ({RVALID_M1, RREADY_S2} !== 2'b00) begin
            n_err++; $display("FAIL s2_after_last: got %b want 00", {RVALID_M1, RREADY_S2});
        end
    endtask

    task automatic test_default();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0005_0000; ARLEN_M0 = 4'd0; ARID_M0 = 4'h9; ARREADY_SD = 1'b1;
        cyc();
        n_cmp++;
        if ({ARVALID_SD, ARID_SD, ARREADY_M0} !== {1'b1, 8'h09, 1'b1}) begin
            n_err++; $display("FAIL sd_ar: got v%b id%h rdy%b want v1 id09 rdy1", ARVALID_SD, ARID_SD, ARREADY_M0);
        end
        n_cmp++;
        if ({ARVALID_S0, ARVALID_S1, ARVALID_S2} !== 3'b000) begin
            n_err++; $display("FAIL sd_other_ar: got %b want 000", {ARVALID_S0, ARVALID_S1, ARVALID_S2});
        end
        cyc();
        clear_ar();
        RVALID_SD = 1'b1; RID_SD = 8'h09; RRESP_SD = 2'b11; RLAST_SD = 1'b1; RREADY_M0 = 1'b1;
        #1;
        n_cmp++;
        if ({RVALID_M0, RRESP_M0, RLAST_M0, RID_M0, RREADY_SD} !== {1'b1, 2'b11, 1'b1, 4'h9, 1'b1}) begin
            n_err++; $display("FAIL sd_resp: got v%b resp%b l%b id%h rr%b want v1 resp11 l1 id9 rr1",
                              RVALID_M0, RRESP_M0, RLAST_M0, RID_M0, RREADY_SD);
        end
        n_cmp++;
        if ({ARVALID_S0, ARVALID_S1, ARVALID_S2, RREADY_S0} !== 4'b0000) begin
            n_err++; $display("FAIL sd_other_data: got %b want 0000", {ARVALID_S0, ARVALID_S1, ARVALID_S2, RREADY_S0});
        end
        cyc();
        clear_r();
    endtask

    task automatic test_simultaneous();
        ARESETn = 1'b0;
        cyc(); cyc();
        ARESETn = 1'b1;
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0000; ARID_M0 = 4'hA;
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0000_0020; ARID_M1 = 4'h6;
        ARREADY_S0 = 1'b1; ARREADY_S1 = 1'b1;
        cyc();
        n_cmp++;
        if ({ARVALID_S1, ARID_S1, ARVALID_S0, ARREADY_M0, ARREADY_M1} !== {1'b1, 8'h0A, 1'b0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL sim_first_m0: got s1v%b id%h s0v%b r0%b r1%b want 1 0a 0 1 0",
                              ARVALID_S1, ARID_S1, ARVALID_S0, ARREADY_M0, ARREADY_M1);
        end
        cyc();
        ARVALID_M0 = 1'b0;
        RVALID_S1 = 1'b1; RID_S1 = 8'h0A; RLAST_S1 = 1'b1; RREADY_M0 = 1'b1;
        #1;
        n_cmp++;
        if ({RVALID_M0, RVALID_M1, ARREADY_M1} !== 3'b100) begin
            n_err++; $display("FAIL sim_m0_data: got %b want 100", {RVALID_M0, RVALID_M1, ARREADY_M1});
        end
        cyc();
        clear_r();
        #1;
        n_cmp++;
        if ({ARVALID_S0, ARREADY_M1} !== 2'b00) begin
            n_err++; $display("FAIL sim_dead_cycle: got %b want 00", {ARVALID_S0, ARREADY_M1});
        end
        cyc();
        n_cmp++;
        if ({ARVALID_S0, ARID_S0, ARREADY_M1} !== {1'b1, 8'h16, 1'b1}) begin
            n_err++; $display("FAIL sim_second_m1: got v%b id%h r%b want v1 id16 r1", ARVALID_S0, ARID_S0, ARREADY_M1);
        end
        cyc();
        ARVALID_M1 = 1'b0;
        RVALID_S0 = 1'b1; RID_S0 = 8'h16; RLAST_S0 = 1'b1; RREADY_M1 = 1'b1;
        #1;
        n_cmp++;
        if ({RVALID_M1, RID_M1} !== {1'b1, 4'h6}) begin
            n_err++; $display("FAIL sim_m1_data: got v%b id%h want v1 id6", RVALID_M1, RID_M1);
        end
        cyc();
        clear_r();
        // Two completions since reset: priority has toggled M0->M1->M0.
        ARVALID_M0 = 1'b1; ARID_M0 = 4'hC;
        ARVALID_M1 = 1'b1; ARID_M1 = 4'hD;
        cyc();
        n_cmp++;
        if ({ARVALID_S1, ARID_S1, ARVALID_S0} !== {1'b1, 8'h0C, 1'b0}) begin
            n_err++; $display("FAIL sim_third_pair: got s1v%b id%h s0v%b want 1 0c 0", ARVALID_S1, ARID_S1, ARVALID_S0);
        end
        cyc();
        ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
        RVALID_S1 = 1'b1; RID_S1 = 8'h0C; RLAST_S1 = 1'b1; RREADY_M0 = 1'b1;
        cyc();
        clear_r();
        clear_ar();
    endtask

    task automatic test_arready_delay();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0000_0040; ARID_M0 = 4'h2; ARREADY_S0 = 1'b0;
        RVALID_S0 = 1'b1; RLAST_S0 = 1'b1; RDATA_S0 = 32'hDEAD_BEEF; RREADY_M0 = 1'b1;
        cyc();
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0001_0000; ARID_M1 = 4'h4;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if ({ARREADY_M0, ARVALID_S0, ARADDR_S0, ARID_S0} !== {1'b0, 1'b1, 32'h0000_0040, 8'h02}) begin
                n_err++; $display("FAIL dly_wait%0d: got r%b v%b a%h id%h want r0 v1 a00000040 id02",
                                  k, ARREADY_M0, ARVALID_S0, ARADDR_S0, ARID_S0);
            end
            n_cmp++;
            if ({RVALID_M0, RREADY_S0, ARREADY_M1, ARVALID_S1} !== 4'b0000) begin
                n_err++; $display("FAIL dly_noroute%0d: got %b want 0000", k, {RVALID_M0, RREADY_S0, ARREADY_M1, ARVALID_S1});
            end
            cyc();
        end
        ARREADY_S0 = 1'b1;
        #1;
        n_cmp++;
        if (ARREADY_M0 !== 1'b1) begin n_err++; $display("FAIL dly_handshake: got %b want 1", ARREADY_M0); end
        cyc();
        clear_ar();
        RID_S0 = 8'h02; RDATA_S0 = 32'h1234_5678;
        #1;
        n_cmp++;
        if ({RVALID_M0, RDATA_M0, ARREADY_M1} !== {1'b1, 32'h1234_5678, 1'b0}) begin
            n_err++; $display("FAIL dly_data: got v%b d%h r1%b want v1 d12345678 r1 0", RVALID_M0, RDATA_M0, ARREADY_M1);
        end
        cyc();
        clear_r();
    endtask

    task automatic test_reset_mid();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0000; ARLEN_M0 = 4'd3; ARID_M0 = 4'h1; ARREADY_S1 = 1'b1;
        cyc();
        cyc();
        clear_ar();
        RVALID_S1 = 1'b1; RID_S1 = 8'h01; RDATA_S1 = 32'hA0; RLAST_S1 = 1'b0; RREADY_M0 = 1'b1;
        #1;
        n_cmp++;
        if ({RVALID_M0, RREADY_S1} !== 2'b11) begin
            n_err++; $display("FAIL rst_beat1: got %b want 11", {RVALID_M0, RREADY_S1});
        end
        cyc();
        RDATA_S1 = 32'hA1;
        ARESETn = 1'b0;
        cyc();
        n_cmp++;
        if ({RVALID_M0, RREADY_S1, ARREADY_M0, RDATA_M0, RID_M0} !== 39'h0) begin
            n_err++; $display("FAIL rst_mid: got v%b rr%b ar%b d%h id%h want all 0",
                              RVALID_M0, RREADY_S1, ARREADY_M0, RDATA_M0, RID_M0);
        end
        ARESETn = 1'b1;
        clear_r();
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0001_0040; ARID_M1 = 4'h7; ARLEN_M1 = 4'd0; ARREADY_S1 = 1'b1;
        cyc();
        n_cmp++;
        if ({ARVALID_S1, ARID_S1, ARADDR_S1, ARREADY_M1} !== {1'b1, 8'h17, 32'h0001_0040, 1'b1}) begin
            n_err++; $display("FAIL rst_fresh_ar: got v%b id%h a%h r%b want v1 id17 a00010040 r1",
                              ARVALID_S1, ARID_S1, ARADDR_S1, ARREADY_M1);
        end
        cyc();
        clear_ar();
        RVALID_S1 = 1'b1; RID_S1 = 8'h17; RDATA_S1 = 32'h77; RLAST_S1 = 1'b1; RREADY_M1 = 1'b1;
        #1;
        n_cmp++;
        if ({RVALID_M1, RID_M1, RDATA_M1, RLAST_M1} !== {1'b1, 4'h7, 32'h77, 1'b1}) begin
            n_err++; $display("FAIL rst_fresh_r: got v%b id%h d%h l%b want v1 id7 d77 l1",
                              RVALID_M1, RID_M1, RDATA_M1, RLAST_M1);
        end
        cyc();
        clear_r();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_s0();
        test_burst_s2();
        test_default();
        test_simultaneous();
        test_arready_delay();
        test_reset_mid();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
